// File: rtl/mips_define.sv
// Shared pipeline definitions: stage indices/masks and hazard FSM encodings.
package mips_define;

    localparam int unsigned NUM_STG = 5;

    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EXE = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    localparam logic [NUM_STG-1:0] M_IF  = NUM_STG'(1) << STG_IF;
    localparam logic [NUM_STG-1:0] M_ID  = NUM_STG'(1) << STG_ID;
    localparam logic [NUM_STG-1:0] M_EXE = NUM_STG'(1) << STG_EXE;
    localparam logic [NUM_STG-1:0] M_MEM = NUM_STG'(1) << STG_MEM;
    localparam logic [NUM_STG-1:0] M_WB  = NUM_STG'(1) << STG_WB;

    typedef enum logic [1:0] {
        HS_RUN   = 2'd0,
        HS_LWAIT = 2'd1,
        HS_MWAIT = 2'd2,
        HS_HALT  = 2'd3
    } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding source search: nearest matching producer wins.
module fwd_select #(
    parameter int unsigned AW         = 5,
    parameter int unsigned FWD_STAGES = 3,
    parameter int unsigned LOAD_FWD   = 1
) (
    input  logic [AW-1:0]                      addr,
    input  logic                               used,
    input  logic [FWD_STAGES-1:0]              prod_wen,
    input  logic [FWD_STAGES*AW-1:0]           prod_waddr,
    input  logic [FWD_STAGES-1:0]              prod_load,
    output logic [$clog2(FWD_STAGES+1)-1:0]    fwd,
    output logic                               lmd,
    output logic                               not_ready
);

    localparam int unsigned FW = $clog2(FWD_STAGES + 1);

    // Operand participates only when read and not the hardwired-zero register.
    logic active;
    assign active = used && (addr != '0);

    // Priority chain built from the farthest producer inward so index 0 lands last.
    logic [FW-1:0] code_ch [FWD_STAGES+1];
    logic          lmd_ch  [FWD_STAGES+1];
    logic          nr_ch   [FWD_STAGES+1];

    assign code_ch[FWD_STAGES] = '0;
    assign lmd_ch[FWD_STAGES]  = 1'b0;
    assign nr_ch[FWD_STAGES]   = 1'b0;

    for (genvar k = 0; k < int'(FWD_STAGES); k++) begin : g_prod
        localparam bit EARLY = (unsigned'(k) < LOAD_FWD);
        logic hit;
        assign hit        = prod_wen[k] && (prod_waddr[k*AW +: AW] == addr);
        assign code_ch[k] = hit ? FW'(k + 1) : code_ch[k+1];
        assign lmd_ch[k]  = hit ? prod_load[k] : lmd_ch[k+1];
        assign nr_ch[k]   = hit ? (prod_load[k] && EARLY) : nr_ch[k+1];
    end

    assign fwd       = active ? code_ch[0] : '0;
    assign lmd       = active && lmd_ch[0];
    assign not_ready = active && nr_ch[0];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage pipeline.
module pipe_hazard_ctrl
    import mips_define::*;
#(
    parameter int unsigned AW          = 5,
    parameter int unsigned FWD_STAGES  = 3,
    parameter int unsigned LOAD_FWD    = 1,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                debug_en,
    input  logic                                debug_step,
    input  logic [AW-1:0]                       rs_addr,
    input  logic [AW-1:0]                       rt_addr,
    input  logic                                rs_used,
    input  logic                                rt_used,
    input  logic                                is_store,
    input  logic [FWD_STAGES-1:0]               prod_wen,
    input  logic [FWD_STAGES*AW-1:0]            prod_waddr,
    input  logic [FWD_STAGES-1:0]               prod_load,
    input  logic                                irq_flush,
    input  logic                                inst_stall,
    input  logic                                mem_stall,
    output logic [$clog2(FWD_STAGES+1)-1:0]     fwd_a,
    output logic [$clog2(FWD_STAGES+1)-1:0]     fwd_b,
    output logic                                fwd_a_lmd,
    output logic                                fwd_b_lmd,
    output logic                                mem_fwd_m,
    output logic [NUM_STG-1:0]                  stage_en,
    output logic [NUM_STG-1:0]                  stage_rst,
    output logic                                mem_timeout,
    output logic [CNT_W-1:0]                    cnt_load,
    output logic [CNT_W-1:0]                    cnt_mem
);

    localparam int unsigned FW  = $clog2(FWD_STAGES + 1);
    localparam int unsigned WDW = $clog2(MEM_TIMEOUT + 1);

    hz_state_t      state;
    hz_state_t      next_state;
    logic [WDW-1:0] wd;
    logic [WDW-1:0] wd_next;
    logic           step_q;

    logic a_nr;
    logic b_nr;
    logic store_fwd;
    logic load_stall;
    logic step_edge;
    logic dbg_hold;
    logic mem_win;

    fwd_select #(
        .AW         (AW),
        .FWD_STAGES (FWD_STAGES),
        .LOAD_FWD   (LOAD_FWD)
    ) u_fwd_a (
        .addr       (rs_addr),
        .used       (rs_used),
        .prod_wen   (prod_wen),
        .prod_waddr (prod_waddr),
        .prod_load  (prod_load),
        .fwd        (fwd_a),
        .lmd        (fwd_a_lmd),
        .not_ready  (a_nr)
    );

    fwd_select #(
        .AW         (AW),
        .FWD_STAGES (FWD_STAGES),
        .LOAD_FWD   (LOAD_FWD)
    ) u_fwd_b (
        .addr       (rt_addr),
        .used       (rt_used),
        .prod_wen   (prod_wen),
        .prod_waddr (prod_waddr),
        .prod_load  (prod_load),
        .fwd        (fwd_b),
        .lmd        (fwd_b_lmd),
        .not_ready  (b_nr)
    );

    // Store data from a load one stage ahead is picked up in MEM instead of stalling.
    assign store_fwd  = b_nr && is_store && (fwd_b == FW'(LOAD_FWD));
    assign mem_fwd_m  = store_fwd;
    assign load_stall = a_nr || (b_nr && !store_fwd);

    assign step_edge  = debug_step && !step_q;
    assign dbg_hold   = debug_en && !step_edge;
    assign mem_win    = mem_stall && !load_stall && !irq_flush && !inst_stall;

    // Per-stage enable/bubble selection, highest-priority cause only.
    always_comb begin
        stage_en  = '1;
        stage_rst = '0;
        if (rst) begin
            stage_rst = '1;
        end else if (dbg_hold) begin
            stage_en = '0;
        end else if (load_stall) begin
            stage_en  = ~(M_IF | M_ID);
            stage_rst = M_EXE;
        end else if (irq_flush) begin
            stage_rst = M_ID;
        end else if (inst_stall) begin
            stage_en  = ~(M_IF | M_ID);
            stage_rst = M_EXE;
        end else if (mem_stall) begin
            stage_en  = M_WB;
            stage_rst = M_WB;
        end
    end

    // Next stall state and consecutive memory-wait count.
    always_comb begin
        next_state = HS_RUN;
        wd_next    = '0;
        if (dbg_hold) begin
            next_state = HS_HALT;
        end else if (mem_win) begin
            next_state = HS_MWAIT;
        end else if (load_stall) begin
            next_state = HS_LWAIT;
        end
        if (next_state == HS_MWAIT) begin
            wd_next = (state == HS_MWAIT) ? wd : '0;
            if (wd_next < WDW'(MEM_TIMEOUT)) begin
                wd_next = wd_next + WDW'(1);
            end
        end
    end

    // State, saturating counters, sticky watchdog and step-edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HS_RUN;
            cnt_load    <= '0;
            cnt_mem     <= '0;
            wd          <= '0;
            mem_timeout <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            state  <= next_state;
            step_q <= debug_step;
            wd     <= wd_next;
            if ((next_state == HS_LWAIT) && (cnt_load != '1)) begin
                cnt_load <= cnt_load + CNT_W'(1);
            end
            if ((next_state == HS_MWAIT) && (cnt_mem != '1)) begin
                cnt_mem <= cnt_mem + CNT_W'(1);
            end
            if (wd_next >= WDW'(MEM_TIMEOUT)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with default parameters.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        debug_en;
    logic        debug_step;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_used;
    logic        rt_used;
    logic        is_store;
    logic [2:0]  prod_wen;
    logic [14:0] prod_waddr;
    logic [2:0]  prod_load;
    logic        irq_flush;
    logic        inst_stall;
    logic        mem_stall;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        fwd_a_lmd;
    logic        fwd_b_lmd;
    logic        mem_fwd_m;
    logic [4:0]  stage_en;
    logic [4:0]  stage_rst;
    logic        mem_timeout;
    logic [15:0] cnt_load;
    logic [15:0] cnt_mem;

    int tests;
    int fails;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .debug_en    (debug_en),
        .debug_step  (debug_step),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_used     (rs_used),
        .rt_used     (rt_used),
        .is_store    (is_store),
        .prod_wen    (prod_wen),
        .prod_waddr  (prod_waddr),
        .prod_load   (prod_load),
        .irq_flush   (irq_flush),
        .inst_stall  (inst_stall),
        .mem_stall   (mem_stall),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .fwd_a_lmd   (fwd_a_lmd),
        .fwd_b_lmd   (fwd_b_lmd),
        .mem_fwd_m   (mem_fwd_m),
        .stage_en    (stage_en),
        .stage_rst   (stage_rst),
        .mem_timeout (mem_timeout),
        .cnt_load    (cnt_load),
        .cnt_mem     (cnt_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_addr = '0; rt_addr = '0; rs_used = 0; rt_used = 0; is_store = 0;
        prod_wen = '0; prod_waddr = '0; prod_load = '0;
        irq_flush = 0; inst_stall = 0; mem_stall = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1; debug_en = 0; debug_step = 0;
        idle();

        // Reset state
        next_cyc();
        #1;
        check("rst_stage_rst", 32'(stage_rst), 32'h1F);
        check("rst_stage_en", 32'(stage_en), 32'h1F);
        check("rst_cnt_load", 32'(cnt_load), 0);
        check("rst_cnt_mem", 32'(cnt_mem), 0);
        check("rst_timeout", 32'(mem_timeout), 0);

        // Plain ALU forward from EXE
        next_cyc();
        rst = 0;
        prod_wen = 3'b001; prod_waddr[4:0] = 5'd5; rs_addr = 5'd5; rs_used = 1;
        #1;
        check("alu_fwd_a", 32'(fwd_a), 1);
        check("alu_fwd_a_lmd", 32'(fwd_a_lmd), 0);
        check("alu_stage_en", 32'(stage_en), 32'h1F);
        check("alu_stage_rst", 32'(stage_rst), 0);

        // Load-use on rt: one bubble
        next_cyc();
        idle();
        prod_wen = 3'b001; prod_load = 3'b001; prod_waddr[4:0] = 5'd7;
        rt_addr = 5'd7; rt_used = 1;
        #1;
        check("lu_stage_en", 32'(stage_en), 32'b11100);
        check("lu_stage_rst", 32'(stage_rst), 32'b00100);
        check("lu_fwd_b", 32'(fwd_b), 1);
        check("lu_mem_fwd_m", 32'(mem_fwd_m), 0);

        // Load has moved to MEM: forwardable
        next_cyc();
        prod_wen = 3'b010; prod_load = 3'b010; prod_waddr = '0; prod_waddr[9:5] = 5'd7;
        #1;
        check("lu2_fwd_b", 32'(fwd_b), 2);
        check("lu2_fwd_b_lmd", 32'(fwd_b_lmd), 1);
        check("lu2_stage_en", 32'(stage_en), 32'h1F);
        check("lu2_cnt_load", 32'(cnt_load), 1);

        // Store whose data comes from a load in EXE
        next_cyc();
        idle();
        prod_wen = 3'b001; prod_load = 3'b001; prod_waddr[4:0] = 5'd7;
        rt_addr = 5'd7; rt_used = 1; is_store = 1;
        #1;
        check("st_mem_fwd_m", 32'(mem_fwd_m), 1);
        check("st_stage_en", 32'(stage_en), 32'h1F);

        // Same store, but rs also depends on the load: still stalls
        next_cyc();
        rs_addr = 5'd7; rs_used = 1;
        #1;
        check("st_rs_stage_en", 32'(stage_en), 32'b11100);
        check("st_rs_mem_fwd_m", 32'(mem_fwd_m), 1);

        // Nearest producer wins
        next_cyc();
        idle();
        prod_wen = 3'b011; prod_waddr[4:0] = 5'd3; prod_waddr[9:5] = 5'd3;
        rs_addr = 5'd3; rs_used = 1;
        #1;
        check("near_fwd_a", 32'(fwd_a), 1);
        check("near_cnt_load", 32'(cnt_load), 2);

        // r0 never forwards; WB producer forwards as code 3
        next_cyc();
        idle();
        prod_wen = 3'b101; prod_waddr[4:0] = 5'd0; prod_waddr[14:10] = 5'd9;
        rs_addr = 5'd0; rs_used = 1; rt_addr = 5'd9; rt_used = 1;
        #1;
        check("r0_fwd_a", 32'(fwd_a), 0);
        check("wb_fwd_b", 32'(fwd_b), 3);

        // Flush alone
        next_cyc();
        idle();
        irq_flush = 1;
        #1;
        check("flush_stage_rst", 32'(stage_rst), 32'b00010);
        check("flush_stage_en", 32'(stage_en), 32'h1F);

        // Flush with load-use: stall wins
        next_cyc();
        prod_wen = 3'b001; prod_load = 3'b001; prod_waddr[4:0] = 5'd7;
        rt_addr = 5'd7; rt_used = 1;
        #1;
        check("flush_lu_stage_rst", 32'(stage_rst), 32'b00100);
        check("flush_lu_stage_en", 32'(stage_en), 32'b11100);

        // I-side stall
        next_cyc();
        idle();
        inst_stall = 1;
        #1;
        check("istall_stage_en", 32'(stage_en), 32'b11100);
        check("istall_stage_rst", 32'(stage_rst), 32'b00100);
        check("istall_cnt_load", 32'(cnt_load), 3);

        // D-side stall held 260 cycles
        next_cyc();
        idle();
        mem_stall = 1;
        #1;
        check("mstall_stage_en", 32'(stage_en), 32'b10000);
        check("mstall_stage_rst", 32'(stage_rst), 32'b10000);
        for (int i = 1; i <= 260; i++) begin
            next_cyc();
            if (i == 254) check("wd_254_timeout", 32'(mem_timeout), 0);
            if (i == 255) check("wd_255_timeout", 32'(mem_timeout), 1);
        end
        mem_stall = 0;
        check("mstall_cnt_mem", 32'(cnt_mem), 260);
        check("mstall_timeout", 32'(mem_timeout), 1);
        check("mstall_cnt_load", 32'(cnt_load), 3);
        next_cyc();
        check("timeout_sticky", 32'(mem_timeout), 1);
        check("cnt_mem_hold", 32'(cnt_mem), 260);

        // Reset mid-MWAIT
        mem_stall = 1;
        next_cyc();
        rst = 1;
        #1;
        check("midrst_stage_en", 32'(stage_en), 32'h1F);
        check("midrst_stage_rst", 32'(stage_rst), 32'h1F);
        next_cyc();
        check("midrst_cnt_mem", 32'(cnt_mem), 0);
        check("midrst_cnt_load", 32'(cnt_load), 0);
        check("midrst_timeout", 32'(mem_timeout), 0);
        rst = 0;
        mem_stall = 0;

        // Debug hold overrides a memory stall and freezes counting
        next_cyc();
        debug_en = 1; mem_stall = 1;
        #1;
        check("hold_stage_en", 32'(stage_en), 0);
        check("hold_stage_rst", 32'(stage_rst), 0);
        next_cyc();
        check("hold_cnt_mem", 32'(cnt_mem), 0);
        mem_stall = 0;

        // Single step with debug_step held for 4 cycles
        debug_step = 1;
        #1;
        check("step0_stage_en", 32'(stage_en), 32'h1F);
        next_cyc();
        check("step1_stage_en", 32'(stage_en), 0);
        next_cyc();
        check("step2_stage_en", 32'(stage_en), 0);
        next_cyc();
        check("step3_stage_en", 32'(stage_en), 0);
        next_cyc();
        debug_step = 0;
        #1;
        check("step_low_stage_en", 32'(stage_en), 0);
        next_cyc();
        debug_step = 1;
        #1;
        check("step_again_stage_en", 32'(stage_en), 32'h1F);
        next_cyc();
        debug_step = 0;
        debug_en = 0;
        #1;
        check("run_stage_en", 32'(stage_en), 32'h1F);
        check("end_cnt_load", 32'(cnt_load), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and stall controller for the 5-stage MIPS pipeline. It replaces the fixed EXE/MEM forwarding logic inside the decode controller with a block that is generic over:
- forwarding depth;
- load-data availability stage;
- register-file size.

It adds registered behaviour on top of that: a stall-state FSM, a memory-stall watchdog and saturating stall counters. It sits beside the instruction decoder in ID and drives the per-stage enable/reset lines of IF, ID, EXE, MEM and WB.

## Interface
Parameters:
- AW, 5: register address width; address 0 is hardwired zero and never matches.
- FWD_STAGES, 3: number of producer stages after ID. Index 0 = EXE, 1 = MEM, 2 = WB.
- LOAD_FWD, 1: lowest producer index whose load data is forwardable.
- MEM_TIMEOUT, 255: cycles of continuous mem_stall before the watchdog fires.
- CNT_W, 16: width of the stall counters.

Ports (FS = FWD_STAGES, FW = $clog2(FS+1)):
- clk  in  1  clock; reset rst, synchronous, active-high.
- rst  in  1  synchronous active-high reset.
- debug_en  in  1  hold the pipeline except on step cycles.
- debug_step  in  1  single-step request; acts on its rising edge.
- rs_addr, rt_addr  in  AW each  source registers of the instruction in ID.
- rs_used, rt_used  in  1 each  the instruction in ID reads rs / rt.
- is_store  in  1  the instruction in ID is a store; rt is consumed only in MEM.
- prod_wen  in  FS  per-producer register write enable.
- prod_waddr  in  FS*AW  per-producer write address; producer k occupies bits [k*AW +: AW].
- prod_load  in  FS  the producer is a load.
- irq_flush  in  1  taken jump, branch or interrupt redirect; squashes ID.
- inst_stall  in  1  I-side memory not ready.
- mem_stall  in  1  D-side memory not ready.
- fwd_a, fwd_b  out  FW each  operand source. 0 = register file; k+1 = producer k.
- fwd_a_lmd, fwd_b_lmd  out  1 each  the selected producer supplies load data rather than its ALU result.
- mem_fwd_m  out  1  store data must be taken from the load result in MEM.
- stage_en  out  5  enables for IF, ID, EXE, MEM, WB (bit 0 = IF).
- stage_rst  out  5  bubble or reset per stage, same bit order.
- mem_timeout  out  1  sticky watchdog flag.
- cnt_load, cnt_mem  out  CNT_W each  saturating stall-cycle counters.

## Operation
Forwarding (combinational), evaluated per operand for k = 0..FS-1:
- Producer k matches when prod_wen[k] is high, prod_waddr[k] equals the operand address, and that address is non-zero.
- The lowest matching k wins.
- fwd = k+1; fwd_*_lmd = prod_load[k].
- No match, or the operand is unused: fwd = 0, lmd = 0.

Load-use handling:
- If the winning producer is a load with k < LOAD_FWD, the operand is not ready.
- Special case: operand is rt, is_store = 1, and k+1 = LOAD_FWD. Then mem_fwd_m = 1 and there is no stall.
- Otherwise the operand is not ready: load_stall = 1.

Stage-control priority, highest first; stage_en defaults to all 1 and stage_rst to all 0:
- rst: stage_rst = 5'b11111.
- debug hold (debug_en and no step edge this cycle): stage_en = 0.
- load_stall: IF and ID enables 0; EXE rst 1.
- irq_flush: ID rst 1.
- inst_stall: IF and ID enables 0; EXE rst 1.
- mem_stall: IF, ID, EXE and MEM enables 0; WB rst 1.

Step edge is defined as debug_step & ~step_q, where step_q is debug_step registered.

FSM `state` (RUN, LWAIT, MWAIT, HALT) drives the counters only:
- Next state, by priority:
  - HALT while in debug hold;
  - otherwise MWAIT when mem_stall is the winning cause;
  - otherwise LWAIT when load_stall is the winning cause;
  - otherwise RUN.
- cnt_load increments in each LWAIT cycle; cnt_mem increments in each MWAIT cycle. Both saturate at all-ones.
- A watchdog counter wd counts consecutive MWAIT cycles and clears on any other state.
- When wd reaches MEM_TIMEOUT, mem_timeout is set and stays high until rst. wd saturates.

## Timing
- Forwarding, mem_fwd_m, stage_en and stage_rst are combinational from the current inputs and step_q. They have zero latency.
- State, counters, wd, mem_timeout and step_q update on the posedge.
- Reset values: state RUN, cnt_load 0, cnt_mem 0, wd 0, mem_timeout 0, step_q 0.
  - During rst, stage_rst = 11111 and stage_en = 11111.
- A load-use bubble lasts exactly LOAD_FWD-k cycles, as the producer advances one stage per cycle.
- Counters are observed one cycle after the stalled cycle.
- Debug step: one advance cycle per 0->1 edge of debug_step. Holding debug_step high gives only one step.
- Simultaneous load_stall and irq_flush: the stall wins and the flush is re-evaluated next cycle, because the producer stays in place.
- Reset asserted mid-MWAIT: everything clears on the next edge; mem_timeout also clears.

## Structure
- Shared package mips_define (existing):
  - stage index constants STG_IF..STG_WB;
  - FSM state encodings HS_RUN, HS_LWAIT, HS_MWAIT, HS_HALT.
- Sub-module fwd_select, instantiated once per operand:
  - inputs: address, used flag, and the producer vectors;
  - outputs: fwd code, lmd flag and not-ready flag;
  - contains the priority search.

## Test plan
- Defaults: producer 0 writes r5 ALU result; ID reads rs = r5 -> fwd_a = 1, fwd_a_lmd = 0, no stall.
- Producer 0 is a load to r7; ID is add using rt = r7 -> stage_en = 11100 (IF, ID held), EXE rst for 1 cycle; next cycle fwd_b = 2, fwd_b_lmd = 1; cnt_load = 1.
- Producer 0 is a load to r7; ID is sw with rt = r7 -> mem_fwd_m = 1, no stall.
- Producers 0 and 1 both write r3 -> fwd_a = 1 (nearest wins). rs = r0 with a producer writing r0 -> fwd_a = 0.
- mem_stall held for 260 cycles with MEM_TIMEOUT = 255 -> mem_timeout rises after 255 MWAIT cycles and stays high; cnt_mem = 260; rst clears all.
- debug_en = 1, debug_step held high for 4 cycles -> stage_en = 11111 for exactly one cycle, then 00000.
